// File: rtl/ex_hilo_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Ports: clk/reset, valid_in/op/x/y issue, cancel flush; accept, busy/hilo_lock, done, dbz, hi, lo.
module ex_hilo_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            cancel,
  output logic            accept,
  output logic            busy,
  output logic            hilo_lock,
  output logic            done,
  output logic            dbz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int NIT = XLEN / DIV_BITS;
  localparam int CW  = $clog2(NIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state_q, state_d;

  logic is_mul, is_div, op_ok;
  logic mul_go, div_go;
  logic mul_wr, div_wr;

  logic [2*XLEN-1:0] mx, my, prod;
  logic [2*XLEN-1:0] mpipe [MUL_STAGES];
  logic [MUL_STAGES-1:0] mvld;

  logic [XLEN-1:0] ax, ay;
  logic            div_sgn;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, xs_q;
  logic            neg_q_q, neg_r_q, dvz_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN:0]   div_t;
  logic [XLEN-1:0] div_r, div_q;
  logic [XLEN-1:0] fix_q, fix_r;

  assign op_ok  = (op != 3'd0) && (op != 3'd7);
  assign is_mul = (op == 3'd1) || (op == 3'd2);
  assign is_div = (op == 3'd3) || (op == 3'd4);

  assign busy      = (state_q != IDLE);
  assign hilo_lock = busy;
  assign accept    = valid_in && op_ok && !busy && !cancel;

  assign mul_go = accept && is_mul;
  assign div_go = accept && is_div;

  assign mul_wr = mvld[MUL_STAGES-1] && !cancel;
  assign div_wr = (state_q == FIX) && !cancel;

  // Sign/zero extend to full product width; low 2*XLEN bits
  // of the wide product are correct for both signednesses.
  always_comb begin
    mx = {{XLEN{1'b0}}, x};
    my = {{XLEN{1'b0}}, y};
    if (op == 3'd1) begin
      mx = {{XLEN{x[XLEN-1]}}, x};
      my = {{XLEN{y[XLEN-1]}}, y};
    end
    prod = mx * my;
  end

  always_comb begin
    div_sgn = (op == 3'd3);
    ax = (div_sgn && x[XLEN-1]) ? -x : x;
    ay = (div_sgn && y[XLEN-1]) ? -y : y;
  end

  // DIV_BITS chained restoring steps per cycle on magnitudes.
  always_comb begin
    div_r = rem_q;
    div_q = quo_q;
    div_t = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      div_t = {div_r, div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], 1'b0};
      if (div_t >= {1'b0, dvs_q}) begin
        div_t    = div_t - {1'b0, dvs_q};
        div_q[0] = 1'b1;
      end
      div_r = div_t[XLEN-1:0];
    end
  end

  always_comb begin
    fix_q = neg_q_q ? -quo_q : quo_q;
    fix_r = neg_r_q ? -rem_q : rem_q;
    if (dvz_q) begin
      fix_q = '1;
      fix_r = xs_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mul_go)      state_d = MUL;
        else if (div_go) state_d = DIV;
      end
      MUL: begin
        if (cancel || mvld[MUL_STAGES-1]) state_d = IDLE;
      end
      DIV: begin
        if (cancel)                         state_d = IDLE;
        else if (cnt_q == CW'(NIT - 1))     state_d = FIX;
      end
      FIX: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      mvld    <= '0;
    end else begin
      state_q <= state_d;
      done    <= mul_wr || div_wr;
      if (cancel) begin
        mvld <= '0;
      end else begin
        mvld[0] <= mul_go;
        for (int i = 1; i < MUL_STAGES; i++)
          mvld[i] <= mvld[i-1];
      end
      if (mul_wr) begin
        {hi, lo} <= mpipe[MUL_STAGES-1];
      end else if (div_wr) begin
        hi  <= fix_r;
        lo  <= fix_q;
        dbz <= dvz_q;
      end else if (accept && op == 3'd5) begin
        hi <= x;
      end else if (accept && op == 3'd6) begin
        lo <= x;
      end
    end
  end

  always_ff @(posedge clk) begin
    mpipe[0] <= prod;
    for (int i = 1; i < MUL_STAGES; i++)
      mpipe[i] <= mpipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (div_go) begin
      rem_q   <= '0;
      quo_q   <= ax;
      dvs_q   <= ay;
      xs_q    <= x;
      neg_q_q <= div_sgn && (x[XLEN-1] ^ y[XLEN-1]);
      neg_r_q <= div_sgn && x[XLEN-1];
      dvz_q   <= (y == '0);
      cnt_q   <= '0;
    end else if (state_q == DIV) begin
      rem_q <= div_r;
      quo_q <= div_q;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hilo_unit.sv
// Directed self-checking bench for ex_hilo_unit (default parameters).
// Tasks per scenario; each compares inline and steps total/bad.
module tb_ex_hilo_unit;

  logic        clk = 0;
  logic        reset;
  logic        valid_in;
  logic [2:0]  op;
  logic [31:0] x, y;
  logic        cancel;
  logic        accept, busy, hilo_lock, done, dbz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  ex_hilo_unit dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op(op),
    .x(x), .y(y), .cancel(cancel), .accept(accept), .busy(busy),
    .hilo_lock(hilo_lock), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive at negedge, pass E0, return 1ns after E0 with inputs scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_in = 1; op = o; x = a; y = b;
    #1;
    total++;
    if (accept !== 1'b1) begin
      bad++;
      $display("FAIL issue_accept op=%0d got=%b want=1", o, accept);
    end
    @(posedge clk);
    #1;
    valid_in = 0; op = 0; x = 32'h5A5A5A5A; y = 32'hA5A5A5A5;
  endtask

  // Edges from E0 until done is seen; counts busy samples before it.
  task automatic wait_done(output int lat, output int bcy);
    lat = 0; bcy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcy++;
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat >= 100) begin
      bad++;
      $display("FAIL wait_done timeout lat=%0d want<100", lat);
    end
  endtask

  task automatic check_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    total++;
    if (hi !== eh || lo !== el) begin
      bad++;
      $display("FAIL %s hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, eh, el);
    end
  endtask

  task automatic test_reset;
    reset = 1; valid_in = 0; op = 0; x = 0; y = 0; cancel = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    total++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0 || dbz !== 0 || hilo_lock !== 0 || accept !== 0) begin
      bad++;
      $display("FAIL reset hi=%h lo=%h busy=%b done=%b dbz=%b lock=%b acc=%b want all 0",
               hi, lo, busy, done, dbz, hilo_lock, accept);
    end
  endtask

  task automatic test_mult;
    int lat, bcy;
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_done(lat, bcy);
    total++;
    if (lat != 2) begin bad++; $display("FAIL mult_latency got=%0d want=2", lat); end
    check_hilo("mult_result", 32'hFFFFFFFF, 32'hFFFFFFFA);
    @(posedge clk); #1;
    total++;
    if (done !== 0) begin bad++; $display("FAIL mult_done_pulse got=%b want=0", done); end
    issue(3'd1, 32'hFFFFFFFD, 32'hFFFFFFFB);
    wait_done(lat, bcy);
    check_hilo("mult_negneg", 32'h0, 32'd15);
  endtask

  task automatic test_multu;
    int lat, bcy;
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bcy);
    total++;
    if (bcy != 2) begin bad++; $display("FAIL multu_busy got=%0d want=2", bcy); end
    check_hilo("multu_result", 32'hFFFFFFFE, 32'h00000001);
    // back-to-back: issue in the done cycle
    issue(3'd2, 32'h00010000, 32'h00010000);
    wait_done(lat, bcy);
    total++;
    if (lat != 2) begin bad++; $display("FAIL b2b_latency got=%0d want=2", lat); end
    check_hilo("multu_b2b", 32'h1, 32'h0);
  endtask

  task automatic test_div;
    int lat, bcy;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bcy);
    total++;
    if (lat != 33 || bcy != 33) begin
      bad++; $display("FAIL div_latency lat=%0d busy=%0d want 33/33", lat, bcy);
    end
    check_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd3, 32'd7, 32'hFFFFFFFE);
    wait_done(lat, bcy);
    check_hilo("div_negdivisor", 32'h1, 32'hFFFFFFFD);
    issue(3'd4, 32'hFFFFFFFF, 32'h10);
    wait_done(lat, bcy);
    check_hilo("divu_big", 32'hF, 32'h0FFFFFFF);
  endtask

  task automatic test_dbz;
    int lat, bcy;
    issue(3'd4, 32'd100, 32'd0);
    wait_done(lat, bcy);
    check_hilo("divu_by_zero", 32'd100, 32'hFFFFFFFF);
    total++;
    if (dbz !== 1 || lat != 33) begin
      bad++; $display("FAIL dbz_set dbz=%b lat=%0d want 1/33", dbz, lat);
    end
    issue(3'd4, 32'd9, 32'd4);
    wait_done(lat, bcy);
    check_hilo("divu_after_dbz", 32'd1, 32'd2);
    total++;
    if (dbz !== 0) begin bad++; $display("FAIL dbz_clear got=%b want=0", dbz); end
    issue(3'd3, 32'hFFFFFFFB, 32'd0);
    wait_done(lat, bcy);
    check_hilo("div_neg_by_zero", 32'hFFFFFFFB, 32'hFFFFFFFF);
    issue(3'd5, 32'h77, 32'd0);
    total++;
    if (dbz !== 1) begin bad++; $display("FAIL dbz_hold got=%b want=1", dbz); end
  endtask

  task automatic test_overflow_busy;
    int lat, bcy;
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    @(negedge clk);
    valid_in = 1; op = 3'd5; x = 32'h1234;
    #1;
    total++;
    if (accept !== 0 || hilo_lock !== 1) begin
      bad++; $display("FAIL busy_block acc=%b lock=%b want 0/1", accept, hilo_lock);
    end
    @(posedge clk); #1;
    total++;
    if (hi !== 32'h77) begin bad++; $display("FAIL busy_no_write hi=%h want=00000077", hi); end
    valid_in = 0; op = 0;
    wait_done(lat, bcy);
    check_hilo("div_overflow", 32'h0, 32'h80000000);
  endtask

  task automatic test_mt;
    issue(3'd5, 32'h1111, 32'd0);
    total++;
    if (busy !== 0 || done !== 0) begin
      bad++; $display("FAIL mthi_flags busy=%b done=%b want 0/0", busy, done);
    end
    check_hilo("mthi", 32'h1111, 32'h80000000);
    issue(3'd6, 32'h2222, 32'd0);
    check_hilo("mtlo", 32'h1111, 32'h2222);
  endtask

  task automatic test_cancel;
    int seen;
    issue(3'd3, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #1 cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
    total++;
    if (busy !== 0) begin bad++; $display("FAIL cancel_busy got=%b want=0", busy); end
    valid_in = 1; op = 3'd6; x = 32'h3333;
    #1;
    total++;
    if (accept !== 1) begin bad++; $display("FAIL cancel_accept got=%b want=1", accept); end
    valid_in = 0; op = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL cancel_no_done count=%0d want=0", seen); end
    check_hilo("cancel_hold", 32'h1111, 32'h2222);
  endtask

  task automatic test_cancel_idle;
    @(negedge clk);
    valid_in = 1; op = 3'd1; x = 32'd5; y = 32'd5; cancel = 1;
    #1;
    total++;
    if (accept !== 0) begin bad++; $display("FAIL cancel_idle_acc got=%b want=0", accept); end
    @(posedge clk); #1;
    valid_in = 0; cancel = 0; op = 0;
    total++;
    if (busy !== 0) begin bad++; $display("FAIL cancel_idle_busy got=%b want=0", busy); end
    @(negedge clk);
    valid_in = 1; op = 3'd7;
    #1;
    total++;
    if (accept !== 0) begin bad++; $display("FAIL op7_accept got=%b want=0", accept); end
    @(posedge clk); #1;
    valid_in = 0; op = 0;
    check_hilo("op7_hold", 32'h1111, 32'h2222);
  endtask

  task automatic test_cancel_write_edge;
    issue(3'd2, 32'd6, 32'd7);
    @(posedge clk);
    #1 cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
    total++;
    if (busy !== 0 || done !== 0) begin
      bad++; $display("FAIL cancel_wr_flags busy=%b done=%b want 0/0", busy, done);
    end
    check_hilo("cancel_wr_hold", 32'h1111, 32'h2222);
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(3'd1, 32'd3, 32'd4);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    total++;
    if (busy !== 0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    check_hilo("rst_mid_hilo", 32'h0, 32'h0);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_mid_done count=%0d want=0", seen); end
    check_hilo("rst_mid_after", 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_dbz();
    test_overflow_busy();
    test_mt();
    test_cancel();
    test_cancel_idle();
    test_cancel_write_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
